// File: rtl/hf14a_tag_rx_decoder.sv
// ISO14443-A tag-to-reader Manchester frame decoder (SOF / data+parity / EOF).
// Optional collision flagging enabled by defining HF14A_COLLISION_DETECT_EN.
module hf14a_tag_rx_decoder #(
  parameter int SAMPLES_PER_HALF = 4,
  parameter int MOD_THRESH       = 3
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       enable,
  input  logic       sample_stb,
  input  logic       curbit,
  output logic [7:0] byte_data,
  output logic       byte_parity,
  output logic [3:0] byte_bits,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       coll_err,
  output logic       frame_active,
  output logic       frame_end
);

  localparam int CW = $clog2(SAMPLES_PER_HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_HALF - 1);
  localparam logic [CW-1:0] THR  = CW'(MOD_THRESH);

`ifdef HF14A_COLLISION_DETECT_EN
  localparam logic COLL_EN = 1'b1;
`else
  localparam logic COLL_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SOF  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] samp_cnt;
  logic [CW-1:0] ones;
  logic          half_sel;
  logic          first_m;
  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;

  logic [CW-1:0] ones_next;
  logic          half_done;
  logic          half_m;
  logic          sym_done;
  logic          sof_accept;

  always_comb begin
    ones_next  = ones + CW'(curbit);
    half_done  = sample_stb && (state != S_IDLE) && (samp_cnt == LAST);
    half_m     = (ones_next >= THR);
    sym_done   = half_done && half_sel;
    sof_accept = first_m && (!half_m || COLL_EN);
  end

  always_ff @(negedge ck_1356meg or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      samp_cnt     <= '0;
      ones         <= '0;
      half_sel     <= 1'b0;
      first_m      <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      byte_data    <= '0;
      byte_parity  <= 1'b0;
      byte_bits    <= '0;
      byte_valid   <= 1'b0;
      parity_err   <= 1'b0;
      frame_active <= 1'b0;
      frame_end    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_end  <= 1'b0;
      if (!enable) begin
        state        <= S_IDLE;
        frame_active <= 1'b0;
        samp_cnt     <= '0;
        ones         <= '0;
        half_sel     <= 1'b0;
        first_m      <= 1'b0;
        shreg        <= '0;
        bit_cnt      <= '0;
      end else if (sample_stb) begin
        if (state == S_IDLE) begin
          if (curbit) begin
            state <= S_SOF;
            // The triggering sample already counts toward the first SOF half
            if (SAMPLES_PER_HALF == 1) begin
              samp_cnt <= '0;
              ones     <= '0;
              half_sel <= 1'b1;
              first_m  <= 1'b1;
            end else begin
              samp_cnt <= CW'(1);
              ones     <= CW'(1);
              half_sel <= 1'b0;
            end
          end
        end else if (!half_done) begin
          samp_cnt <= samp_cnt + CW'(1);
          ones     <= ones_next;
        end else begin
          samp_cnt <= '0;
          ones     <= '0;
          if (!half_sel) begin
            half_sel <= 1'b1;
            first_m  <= half_m;
          end else begin
            half_sel <= 1'b0;
            if (state == S_SOF) begin
              if (sof_accept) begin
                state        <= S_DATA;
                frame_active <= 1'b1;
                bit_cnt      <= '0;
                shreg        <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else if (!first_m && !half_m) begin
              if (bit_cnt != 4'd0) begin
                byte_data   <= shreg;
                byte_parity <= 1'b0;
                byte_bits   <= bit_cnt;
                parity_err  <= (bit_cnt == 4'd8);
                byte_valid  <= 1'b1;
              end
              frame_end    <= 1'b1;
              frame_active <= 1'b0;
              state        <= S_IDLE;
              bit_cnt      <= '0;
              shreg        <= '0;
            end else if (bit_cnt == 4'd8) begin
              // (M,U) and (M,M) both decode as 1, so the bit is the first half
              byte_data   <= shreg;
              byte_parity <= first_m;
              byte_bits   <= 4'd8;
              parity_err  <= ~(^shreg ^ first_m);
              byte_valid  <= 1'b1;
              bit_cnt     <= '0;
              shreg       <= '0;
            end else begin
              shreg[bit_cnt[2:0]] <= first_m;
              bit_cnt             <= bit_cnt + 4'd1;
            end
          end
        end
      end
    end
  end

`ifdef HF14A_COLLISION_DETECT_EN
  always_ff @(negedge ck_1356meg or posedge rst) begin
    if (rst) begin
      coll_err <= 1'b0;
    end else if (enable && sym_done) begin
      if (state == S_SOF) begin
        if (sof_accept)
          coll_err <= half_m;
      end else if (first_m && half_m) begin
        coll_err <= 1'b1;
      end
    end
  end
`else
  assign coll_err = 1'b0;
`endif

endmodule

// File: tb/tb_hf14a_tag_rx_decoder.sv
// Directed bench for hf14a_tag_rx_decoder: framing, parity, partial bytes, collision, abort/reset.
module tb_hf14a_tag_rx_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       sample_stb = 1'b0;
  logic       curbit = 1'b0;
  logic [7:0] byte_data;
  logic       byte_parity;
  logic [3:0] byte_bits;
  logic       byte_valid;
  logic       parity_err;
  logic       coll_err;
  logic       frame_active;
  logic       frame_end;

  int nvec = 0;
  int nerr = 0;
  int nbv = 0, nfe = 0, nfa = 0, nboth = 0;
  int var_idx = 0;
  logic exp_coll;

  hf14a_tag_rx_decoder #(.SAMPLES_PER_HALF(4), .MOD_THRESH(3)) dut (
    .ck_1356meg  (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_stb  (sample_stb),
    .curbit      (curbit),
    .byte_data   (byte_data),
    .byte_parity (byte_parity),
    .byte_bits   (byte_bits),
    .byte_valid  (byte_valid),
    .parity_err  (parity_err),
    .coll_err    (coll_err),
    .frame_active(frame_active),
    .frame_end   (frame_end)
  );

  always #5 clk = ~clk;

  // DUT updates on negedge; pulses are counted on the opposite edge
  always @(posedge clk) begin
    if (byte_valid) nbv++;
    if (frame_end) nfe++;
    if (frame_active) nfa++;
    if (byte_valid && frame_end) nboth++;
  end

  task automatic stb(input logic b);
    @(posedge clk);
    sample_stb = 1'b1;
    curbit     = b;
    @(posedge clk);
    sample_stb = 1'b0;
    curbit     = 1'b0;
  endtask

  function automatic logic [3:0] pat(input logic m, input int k);
    logic [3:0] p;
    case (k)
      0:       p = m ? 4'b1111 : 4'b0000;
      1:       p = m ? 4'b1011 : 4'b0100;
      default: p = m ? 4'b0111 : 4'b1010;
    endcase
    return p;
  endfunction

  task automatic half(input logic m);
    logic [3:0] p;
    p = pat(m, var_idx);
    var_idx = (var_idx + 1) % 3;
    for (int i = 0; i < 4; i++) stb(p[i]);
  endtask

  task automatic sof();
    for (int i = 0; i < 4; i++) stb(1'b1);
    half(1'b0);
  endtask

  task automatic dbit(input logic b);
    if (b) begin half(1'b1); half(1'b0); end
    else   begin half(1'b0); half(1'b1); end
  endtask

  task automatic eof();
    half(1'b0);
    half(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) dbit(d[i]);
    dbit(p);
  endtask

  task automatic test_reset();
    #1;
    nvec++; if (byte_data !== 8'h00) begin nerr++; $display("FAIL rst_byte_data got %h exp 00", byte_data); end
    nvec++; if (byte_parity !== 1'b0) begin nerr++; $display("FAIL rst_byte_parity got %b exp 0", byte_parity); end
    nvec++; if (byte_bits !== 4'd0) begin nerr++; $display("FAIL rst_byte_bits got %0d exp 0", byte_bits); end
    nvec++; if (byte_valid !== 1'b0) begin nerr++; $display("FAIL rst_byte_valid got %b exp 0", byte_valid); end
    nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL rst_parity_err got %b exp 0", parity_err); end
    nvec++; if (coll_err !== 1'b0) begin nerr++; $display("FAIL rst_coll_err got %b exp 0", coll_err); end
    nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL rst_frame_active got %b exp 0", frame_active); end
    nvec++; if (frame_end !== 1'b0) begin nerr++; $display("FAIL rst_frame_end got %b exp 0", frame_end); end
    @(posedge clk);
    rst = 1'b0;
  endtask

  task automatic test_byte(input logic p);
    int b0, f0;
    b0 = nbv; f0 = nfe;
    sof();
    #1;
    nvec++; if (frame_active !== 1'b1) begin nerr++; $display("FAIL sof_active got %b exp 1", frame_active); end
    send_byte(8'h44, p);
    eof();
    #1;
    nvec++; if (nbv - b0 !== 1) begin nerr++; $display("FAIL b44_valid_count got %0d exp 1", nbv - b0); end
    nvec++; if (byte_data !== 8'h44) begin nerr++; $display("FAIL b44_data got %h exp 44", byte_data); end
    nvec++; if (byte_parity !== p) begin nerr++; $display("FAIL b44_parity got %b exp %b", byte_parity, p); end
    nvec++; if (byte_bits !== 4'd8) begin nerr++; $display("FAIL b44_bits got %0d exp 8", byte_bits); end
    nvec++; if (parity_err !== ~p) begin nerr++; $display("FAIL b44_parity_err got %b exp %b", parity_err, ~p); end
    nvec++; if (nfe - f0 !== 1) begin nerr++; $display("FAIL b44_frame_end_count got %0d exp 1", nfe - f0); end
    nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL b44_active_after got %b exp 0", frame_active); end
  endtask

  task automatic test_ack();
    int c0;
    c0 = nboth;
    sof();
    dbit(1'b0); dbit(1'b1); dbit(1'b0); dbit(1'b1);
    eof();
    #1;
    nvec++; if ({byte_valid, frame_end} !== 2'b11) begin nerr++; $display("FAIL ack_pulses got %b exp 11", {byte_valid, frame_end}); end
    nvec++; if (byte_data !== 8'h0A) begin nerr++; $display("FAIL ack_data got %h exp 0a", byte_data); end
    nvec++; if (byte_bits !== 4'd4) begin nerr++; $display("FAIL ack_bits got %0d exp 4", byte_bits); end
    nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL ack_parity_err got %b exp 0", parity_err); end
    nvec++; if (byte_parity !== 1'b0) begin nerr++; $display("FAIL ack_parity got %b exp 0", byte_parity); end
    @(posedge clk);
    nvec++; if (nboth - c0 !== 1) begin nerr++; $display("FAIL ack_coincident got %0d exp 1", nboth - c0); end
  endtask

  task automatic test_collision();
    int b0;
    sof();
    dbit(1'b0); dbit(1'b0); dbit(1'b0);
    half(1'b1); half(1'b1);
    for (int i = 0; i < 4; i++) dbit(1'b0);
    dbit(1'b0);
    eof();
    #1;
    nvec++; if (byte_data !== 8'h08) begin nerr++; $display("FAIL coll_data got %h exp 08", byte_data); end
    nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL coll_parity_err got %b exp 0", parity_err); end
    nvec++; if (coll_err !== exp_coll) begin nerr++; $display("FAIL coll_flag got %b exp %b", coll_err, exp_coll); end
    for (int i = 0; i < 3; i++) stb(1'b0);
    nvec++; if (coll_err !== exp_coll) begin nerr++; $display("FAIL coll_sticky got %b exp %b", coll_err, exp_coll); end
    b0 = nbv;
    sof();
    #1;
    nvec++; if (coll_err !== 1'b0) begin nerr++; $display("FAIL coll_clear_sof got %b exp 0", coll_err); end
    eof();
    #1;
    nvec++; if (frame_end !== 1'b1) begin nerr++; $display("FAIL empty_frame_end got %b exp 1", frame_end); end
    @(posedge clk);
    nvec++; if (nbv - b0 !== 0) begin nerr++; $display("FAIL empty_no_byte got %0d exp 0", nbv - b0); end
  endtask

  task automatic test_sof_reject();
    int a0, b0, f0;
    a0 = nfa; b0 = nbv; f0 = nfe;
    stb(1'b1); stb(1'b1); stb(1'b0); stb(1'b0);
    for (int i = 0; i < 4; i++) stb(1'b0);
    for (int i = 0; i < 8; i++) stb(1'b0);
    nvec++; if (nfa - a0 !== 0) begin nerr++; $display("FAIL rej_active got %0d cycles exp 0", nfa - a0); end
    nvec++; if (nbv - b0 !== 0) begin nerr++; $display("FAIL rej_valid got %0d exp 0", nbv - b0); end
    nvec++; if (nfe - f0 !== 0) begin nerr++; $display("FAIL rej_frame_end got %0d exp 0", nfe - f0); end
  endtask

  task automatic test_abort();
    int b0, f0;
    b0 = nbv; f0 = nfe;
    sof();
    dbit(1'b1); dbit(1'b0); dbit(1'b1); dbit(1'b1); dbit(1'b0);
    enable = 1'b0;
    @(posedge clk);
    enable = 1'b1;
    #1;
    nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL abort_active got %b exp 0", frame_active); end
    // abort coinciding with the EOF-completing strobe
    sof();
    dbit(1'b1);
    half(1'b0);
    for (int i = 0; i < 3; i++) stb(1'b0);
    @(posedge clk);
    sample_stb = 1'b1; curbit = 1'b0; enable = 1'b0;
    @(posedge clk);
    sample_stb = 1'b0; enable = 1'b1;
    #1;
    nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL abort_eof_active got %b exp 0", frame_active); end
    for (int i = 0; i < 4; i++) stb(1'b0);
    nvec++; if (nbv - b0 !== 0) begin nerr++; $display("FAIL abort_valid got %0d exp 0", nbv - b0); end
    nvec++; if (nfe - f0 !== 0) begin nerr++; $display("FAIL abort_frame_end got %0d exp 0", nfe - f0); end
    sof();
    dbit(1'b1); dbit(1'b1); dbit(1'b0);
    stb(1'b1); stb(1'b1);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    nvec++; if (byte_data !== 8'h00) begin nerr++; $display("FAIL rstmid_data got %h exp 00", byte_data); end
    nvec++; if (byte_bits !== 4'd0) begin nerr++; $display("FAIL rstmid_bits got %0d exp 0", byte_bits); end
    nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL rstmid_active got %b exp 0", frame_active); end
    for (int i = 0; i < 4; i++) stb(1'b0);
    nvec++; if (nbv - b0 !== 0 || nfe - f0 !== 0) begin nerr++; $display("FAIL rstmid_pulses got %0d/%0d exp 0/0", nbv - b0, nfe - f0); end
    test_byte(1'b1);
  endtask

  initial begin
`ifdef HF14A_COLLISION_DETECT_EN
    exp_coll = 1'b1;
`else
    exp_coll = 1'b0;
`endif
    test_reset();
    for (int i = 0; i < 3; i++) stb(1'b0);
    test_byte(1'b1);
    test_byte(1'b0);
    test_ack();
    test_collision();
    test_sof_reject();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hf14a_tag_rx_decoder.md
# hf14a_tag_rx_decoder

Decodes the ISO14443-A tag-to-reader Manchester bitstream from the per-16-carrier-cycle subcarrier modulation-detector decision (`curbit`) in READER_LISTEN mode. It frames the stream into SOF, data bytes with odd parity, and EOF, and presents whole or partial bytes to the ARM-side transfer logic. It sits directly downstream of the 848 kHz edge/modulation detector and upstream of the SSP byte shifter.

## Interface
- `SAMPLES_PER_HALF`, 4: detector decisions per Manchester half-bit (64 fc).
- `MOD_THRESH`, 3: minimum count of `curbit`=1 samples for a half to be classed as modulated; legal range 1..`SAMPLES_PER_HALF`.

- `ck_1356meg`  in  1  carrier clock; all state updates on negedge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  high while major mode is READER_LISTEN; low aborts any frame.
- `sample_stb`  in  1  one-cycle strobe: `curbit` valid this cycle.
- `curbit`  in  1  modulation decision for the last 16 fc window.
- `byte_data`  out  8  decoded byte, LSB first on air; bits above `byte_bits` are 0.
- `byte_parity`  out  1  received parity bit (0 if none received).
- `byte_bits`  out  4  valid data bits in `byte_data`, 1..8.
- `byte_valid`  out  1  one-cycle pulse; byte outputs valid.
- `parity_err`  out  1  qualifies `byte_valid`: odd-parity fail or missing parity.
- `coll_err`  out  1  sticky per frame: collision seen; cleared at next SOF.
- `frame_active`  out  1  high from SOF acceptance to EOF/abort.
- `frame_end`  out  1  one-cycle pulse on EOF.

## Operation
- Half classification: count `curbit`=1 over `SAMPLES_PER_HALF` strobes; modulated (M) if count ≥ `MOD_THRESH`, else U.
- States: IDLE, SOF, DATA.
- IDLE: on a strobe with `curbit`=1, that sample becomes sample 0 of the SOF first half; go to SOF. Strobes with `curbit`=0 are ignored.
- SOF: classify two halves. (M,U) accepts the SOF: set `frame_active`, clear `coll_err`, clear bit counter, go to DATA. Any other pair returns to IDLE silently, with no output pulses.
- DATA: each pair of halves forms one symbol:
  - (M,U) = 1.
  - (U,M) = 0.
  - (U,U) = EOF.
  - (M,M) = collision; see Configuration.
- Data bits shift in LSB first. Bits 0..7 are data; bit 8 is parity.
- After the parity symbol:
  - Pulse `byte_valid` with `byte_bits`=8.
  - `parity_err` = (XOR of data bits and parity) == 0, i.e. odd parity required.
  - Clear the bit counter.
- On EOF:
  - If 1..7 data bits are pending, emit them with `byte_bits`=n, `byte_parity`=0, `parity_err`=0.
  - If exactly 8 data bits are pending without parity, emit with `byte_bits`=8, `parity_err`=1.
  - Pulse `frame_end`, clear `frame_active`, return to IDLE.
- `enable` low in any state: return to IDLE next cycle and clear `frame_active`. No `byte_valid` or `frame_end` is emitted for the aborted frame.
- No frame-length limit. The bit counter wraps per byte only.

## Timing
- Reset values:
  - Outputs: `byte_data`=0, `byte_parity`=0, `byte_bits`=0, `byte_valid`=0, `parity_err`=0, `coll_err`=0, `frame_active`=0, `frame_end`=0.
  - State: IDLE, all counters 0.
- All outputs are registered.
- `byte_valid`, `frame_end`, and `frame_active` changes occur 1 cycle after the `sample_stb` that completes the deciding half.
- The partial-byte `byte_valid` and `frame_end` assert in the same cycle.
- `byte_*` and `parity_err` hold their values until the next `byte_valid`.
- Strobes may arrive on consecutive cycles; in system use they arrive every 16 cycles. Non-strobe cycles never advance state.
- `enable` falling in the same cycle as a completing strobe: the abort wins, with no pulse.
- `rst` asserted mid-frame: immediate return to reset values, with no pulse.

## Configuration
- `HF14A_COLLISION_DETECT_EN` defined:
  - (M,M) decodes as data 1 and sets `coll_err` until next SOF.
  - A (M,M) pair in the SOF state is accepted as SOF and sets `coll_err`.
- Not defined:
  - (M,M) decodes as 1 with no flag; `coll_err` is tied to 0.
  - (M,M) in the SOF state is rejected (return to IDLE).

## Test plan
- SOF, then 0x44 LSB first, parity 1, then EOF: one `byte_valid` with `byte_data`=0x44, `byte_parity`=1, `byte_bits`=8, `parity_err`=0; then `frame_end`; `frame_active` low after.
- Same frame with parity 0: `parity_err`=1 with `byte_data`=0x44.
- SOF, 4-bit ACK 0xA (bits 0,1,0,1), EOF: `byte_valid` and `frame_end` in the same cycle; `byte_data`=0x0A, `byte_bits`=4, `parity_err`=0.
- Collision on bit 3 of 0x00 (macro defined): `byte_data`=0x08, `coll_err`=1 until the next SOF clears it. Macro undefined: `coll_err` stays 0.
- First half with only 2 of 4 samples at 1: the SOF is rejected; no `frame_active`, `byte_valid`, or `frame_end` at any time.
- Drop `enable` after 5 data bits, then separately assert `rst` mid-byte: no pulses; state IDLE; a following clean 0x44 frame decodes correctly.
